// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage MIPS pipeline: produces the global ready,
// the per-stage stall vector and the flush/flushTarget pair.
module pipeline_ctrl #(
    parameter int          MULDIV_CYCLES = 4,
    parameter logic [31:0] RESET_TARGET  = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        MemReady,
    input  logic        IdStallReq,
    input  logic        ExMulDivStart,
    input  logic        ExceptionReq,
    input  logic [31:0] ExceptionTarget,
    input  logic        EretReq,
    input  logic [31:0] EpcValue,
    output logic        ready,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] flushTarget,
    output logic        MulDivDone,
    output logic        dbg_state,
    output logic [4:0]  dbg_cnt
);

    typedef enum logic {
        IDLE   = 1'b0,
        MULDIV = 1'b1
    } state_t;

    localparam logic [4:0] CNT_INIT    = 5'(MULDIV_CYCLES - 1);
    localparam logic [5:0] STALL_MD    = 6'b001111;
    localparam logic [5:0] STALL_LOAD  = 6'b000111;

    state_t      state;
    logic [4:0]  cnt;
    logic        pend;
    logic [31:0] pend_target;

    logic        req_any;
    logic [31:0] req_target;
    logic        flush_c;

    // Exception outranks eret when both arrive together.
    assign req_any    = ExceptionReq | EretReq;
    assign req_target = ExceptionReq ? ExceptionTarget : EpcValue;
    assign flush_c    = MemReady & (pend | req_any);

    assign dbg_state = (state == MULDIV);
    assign dbg_cnt   = cnt;

    always_comb begin
        ready       = 1'b0;
        stall       = 6'b000000;
        flush       = 1'b0;
        flushTarget = 32'h00000000;
        MulDivDone  = 1'b0;
        if (!reset) begin
            flushTarget = RESET_TARGET;
        end else begin
            ready = MemReady;
            if (flush_c) begin
                flush       = 1'b1;
                flushTarget = pend ? pend_target : req_target;
            end else if (state == MULDIV) begin
                // IdStallReq is moot here: ID is already held by the mul/div stall.
                if (cnt != 5'd0) begin
                    stall = STALL_MD;
                end else begin
                    MulDivDone = MemReady;
                end
            end else if (ExMulDivStart) begin
                stall = STALL_MD;
            end else if (IdStallReq) begin
                stall = STALL_LOAD;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= 5'd0;
            pend        <= 1'b0;
            pend_target <= 32'h00000000;
        end else if (!MemReady) begin
            // Frozen pipeline: only latch the first redirect so it is not lost.
            if (!pend && req_any) begin
                pend        <= 1'b1;
                pend_target <= req_target;
            end
        end else if (flush_c) begin
            state <= IDLE;
            cnt   <= 5'd0;
            pend  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ExMulDivStart) begin
                        cnt   <= CNT_INIT;
                        state <= MULDIV;
                    end
                end
                MULDIV: begin
                    if (cnt != 5'd0) begin
                        cnt <= cnt - 5'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
